// File: rtl/pos_pkg.sv
// Shared constants and FSM encoding for the position detector.
// No logic; latency and backpressure are defined by the modules that import it.
// Report IDs double as the error marker seen by the UART transmitter.
package pos_pkg;

    localparam logic [7:0]  MAP_ID   = 8'hF0;
    localparam logic [7:0]  ERR_ID   = 8'hFF;
    localparam logic [15:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_e;

endpackage

// File: rtl/pos_channel.sv
// One sensor channel: threshold register, hysteresis compare, debounce counter.
// Latency: bit flips on the edge that samples the deciding smp_vld; flip is combinational.
// Backpressure: none, every strobed sample is consumed.
module pos_channel #(
    parameter int ADC_W   = 12,
    parameter int HYST    = 16,
    parameter int DEB_CNT = 3,
    parameter int THR_RST = 511
) (
    input  logic             int_clk,
    input  logic             rst_n,
    input  logic             smp_vld,
    input  logic [ADC_W-1:0] smp_dat,
    input  logic             thr_we,
    input  logic [ADC_W-1:0] thr_dat,
    output logic             pos_bit,
    output logic             flip
);

    localparam int             XW       = ADC_W + 1;
    localparam logic [XW-1:0]  MAX_V    = {1'b0, {ADC_W{1'b1}}};
    localparam logic [XW-1:0]  HYST_X   = XW'(HYST);
    localparam logic [3:0]     DEB_LAST = 4'(DEB_CNT - 1);

    logic [ADC_W-1:0] thr_q, thr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic [XW-1:0]    thr_x, hi_sum, hi, lo, smp_x;
    logic             qual_hi, qual_lo, opposite;

    always_comb begin
        thr_x    = {1'b0, thr_q};
        smp_x    = {1'b0, smp_dat};
        hi_sum   = thr_x + HYST_X;
        hi       = (hi_sum > MAX_V) ? MAX_V : hi_sum;
        lo       = (thr_x >= HYST_X) ? (thr_x - HYST_X) : '0;
        qual_hi  = smp_x > hi;
        qual_lo  = smp_x < lo;
        opposite = bit_q ? qual_lo : qual_hi;

        // Compare always uses the registered threshold, so a same-cycle write lands next cycle.
        thr_d = thr_we ? thr_dat : thr_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        flip  = 1'b0;
        if (smp_vld) begin
            if (!opposite) begin
                cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
                cnt_d = '0;
                bit_d = ~bit_q;
                flip  = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= ADC_W'(THR_RST);
            cnt_q <= '0;
            bit_q <= 1'b0;
        end else begin
            thr_q <= thr_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

    assign pos_bit = bit_q;

endmodule

// File: rtl/position_detect_mc.sv
// Multi-channel position detector with ID-request report port; POS_AUTO_REPORT_EN adds map auto-reports.
// Latency: pos_map 1 cycle after deciding sample; report valid 2 edges after the accepting cycle.
// Backpressure: rpt_valid holds stable until rpt_ready; req_ready low while a report is in flight.
module position_detect_mc
    import pos_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ADC_W   = 12,
    parameter int HYST    = 16,
    parameter int DEB_CNT = 3,
    parameter int THR_RST = 511,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic             int_clk,
    input  logic             rst_n,
    input  logic             smp_valid,
    input  logic [CH_W-1:0]  smp_ch,
    input  logic [ADC_W-1:0] smp_data,
    input  logic             thr_we,
    input  logic [CH_W-1:0]  thr_ch,
    input  logic [ADC_W-1:0] thr_data,
    input  logic             req_valid,
    input  logic [7:0]       req_id,
    output logic             req_ready,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [7:0]       rpt_id,
    output logic [15:0]      rpt_data,
    output logic [N_CH-1:0]  pos_map,
    output logic             pos_change
);

    logic [N_CH-1:0]            smp_hit, thr_hit, flip, map;
    logic [N_CH-1:0][ADC_W-1:0] smp_q, smp_d;
    logic                       pos_change_q, pos_change_d;
    state_e                     state_q, state_d;
    logic [7:0]                 id_q, id_d, rpt_id_q, rpt_id_d;
    logic [15:0]                rpt_data_q, rpt_data_d;

    // Equality decode drops out-of-range channel indices without a range check.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            smp_hit[i] = smp_valid && (smp_ch == CH_W'(i));
            thr_hit[i] = thr_we && (thr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pos_channel #(
            .ADC_W  (ADC_W),
            .HYST   (HYST),
            .DEB_CNT(DEB_CNT),
            .THR_RST(THR_RST)
        ) u_ch (
            .int_clk(int_clk),
            .rst_n  (rst_n),
            .smp_vld(smp_hit[g]),
            .smp_dat(smp_data),
            .thr_we (thr_hit[g]),
            .thr_dat(thr_data),
            .pos_bit(map[g]),
            .flip   (flip[g])
        );
    end

    always_comb begin
        smp_d = smp_q;
        for (int i = 0; i < N_CH; i++) begin
            if (smp_hit[i]) smp_d[i] = smp_data;
        end
        pos_change_d = |flip;
    end

`ifdef POS_AUTO_REPORT_EN
    logic auto_pend_q, auto_pend_d, take_auto;
`endif

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        rpt_id_d   = rpt_id_q;
        rpt_data_d = rpt_data_q;
        req_ready  = 1'b0;
`ifdef POS_AUTO_REPORT_EN
        take_auto  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef POS_AUTO_REPORT_EN
                if (auto_pend_q) begin
                    take_auto = 1'b1;
                    id_d      = MAP_ID;
                    state_d   = LOAD;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        id_d    = req_id;
                        state_d = LOAD;
                    end
                end
`else
                req_ready = 1'b1;
                if (req_valid) begin
                    id_d    = req_id;
                    state_d = LOAD;
                end
`endif
            end
            LOAD: begin
                if (id_q < 8'(N_CH)) begin
                    rpt_id_d   = id_q;
                    rpt_data_d = 16'(smp_q[id_q[CH_W-1:0]]);
                end else if (id_q == MAP_ID) begin
                    rpt_id_d   = MAP_ID;
                    rpt_data_d = 16'(map);
                end else begin
                    rpt_id_d   = ERR_ID;
                    rpt_data_d = ERR_DATA;
                end
                state_d = SEND;
            end
            SEND: begin
                if (rpt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef POS_AUTO_REPORT_EN
    // Changes arriving while a report is in flight merge into a single pending map report.
    always_comb begin
        auto_pend_d = (auto_pend_q && !take_auto) || pos_change_q;
    end

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) auto_pend_q <= 1'b0;
        else        auto_pend_q <= auto_pend_d;
    end
`endif

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q        <= '0;
            pos_change_q <= 1'b0;
            state_q      <= IDLE;
            id_q         <= '0;
            rpt_id_q     <= '0;
            rpt_data_q   <= '0;
        end else begin
            smp_q        <= smp_d;
            pos_change_q <= pos_change_d;
            state_q      <= state_d;
            id_q         <= id_d;
            rpt_id_q     <= rpt_id_d;
            rpt_data_q   <= rpt_data_d;
        end
    end

    assign rpt_valid  = (state_q == SEND);
    assign rpt_id     = rpt_id_q;
    assign rpt_data   = rpt_data_q;
    assign pos_map    = map;
    assign pos_change = pos_change_q;

endmodule

// File: tb/tb_position_detect_mc.sv
// Directed bench for position_detect_mc with a report scoreboard; covers POS_AUTO_REPORT_EN when defined.
module tb_position_detect_mc;
    import pos_pkg::*;

    localparam int N_CH  = 4;
    localparam int ADC_W = 12;
    localparam int CH_W  = 2;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] data;
    } rpt_t;

    logic             int_clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             smp_valid = 1'b0;
    logic [CH_W-1:0]  smp_ch = '0;
    logic [ADC_W-1:0] smp_data = '0;
    logic             thr_we = 1'b0;
    logic [CH_W-1:0]  thr_ch = '0;
    logic [ADC_W-1:0] thr_data = '0;
    logic             req_valid = 1'b0;
    logic [7:0]       req_id = '0;
    logic             req_ready;
    logic             rpt_valid;
    logic             rpt_ready = 1'b0;
    logic [7:0]       rpt_id;
    logic [15:0]      rpt_data;
    logic [N_CH-1:0]  pos_map;
    logic             pos_change;

    int tests = 0;
    int fails = 0;
    rpt_t sb_q[$];
    logic [ADC_W-1:0] last_smp [N_CH];
    logic [N_CH-1:0]  exp_map;

    always #5 int_clk = ~int_clk;

    position_detect_mc #(
        .N_CH(N_CH), .ADC_W(ADC_W), .HYST(16), .DEB_CNT(3), .THR_RST(511), .CH_W(CH_W)
    ) dut (
        .int_clk   (int_clk),
        .rst_n     (rst_n),
        .smp_valid (smp_valid),
        .smp_ch    (smp_ch),
        .smp_data  (smp_data),
        .thr_we    (thr_we),
        .thr_ch    (thr_ch),
        .thr_data  (thr_data),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_ready (req_ready),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_id    (rpt_id),
        .rpt_data  (rpt_data),
        .pos_map   (pos_map),
        .pos_change(pos_change)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge int_clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < N_CH; i++) last_smp[i] = '0;
        exp_map = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        model_reset;
    endtask

    function automatic rpt_t model(input logic [7:0] id);
        rpt_t r;
        if (id < 8'(N_CH))   r = '{id: id, data: 16'(last_smp[id[CH_W-1:0]])};
        else if (id == 8'hF0) r = '{id: 8'hF0, data: 16'(exp_map)};
        else                  r = '{id: 8'hFF, data: 16'hFFFF};
        return r;
    endfunction

    task automatic send_smp(input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] val);
        smp_valid = 1'b1;
        smp_ch    = ch;
        smp_data  = val;
        tick;
        smp_valid = 1'b0;
        last_smp[ch] = val;
    endtask

    task automatic write_thr(input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] val);
        thr_we   = 1'b1;
        thr_ch   = ch;
        thr_data = val;
        tick;
        thr_we   = 1'b0;
    endtask

    task automatic collect_report(input string tag);
        int   n = 0;
        rpt_t e = '1;
        while (rpt_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_vld"}, 32'(rpt_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        rpt_ready = 1'b1;
        chk({tag, "_id"}, 32'(rpt_id), 32'(e.id));
        chk({tag, "_data"}, 32'(rpt_data), 32'(e.data));
        tick;
        rpt_ready = 1'b0;
        chk({tag, "_done"}, 32'(rpt_valid), 32'd0);
    endtask

    task automatic smp_run(input string tag, input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] val,
                           input int n, input logic [N_CH-1:0] new_map);
        for (int i = 0; i < n; i++) send_smp(ch, val);
        chk({tag, "_map"}, 32'(pos_map), 32'(new_map));
        chk({tag, "_chg"}, 32'(pos_change), 32'(new_map != exp_map));
        if (new_map != exp_map) begin
            exp_map = new_map;
`ifdef POS_AUTO_REPORT_EN
            sb_q.push_back('{id: MAP_ID, data: 16'(exp_map)});
            collect_report({tag, "_auto"});
`endif
        end
    endtask

    task automatic run_req(input string tag, input logic [7:0] id, input int hold);
        rpt_t e = model(id);
        sb_q.push_back(e);
        req_id    = id;
        req_valid = 1'b1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        chk({tag, "_lat_t1"}, 32'(rpt_valid), 32'd0);
        tick;
        chk({tag, "_lat_t2"}, 32'(rpt_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, "_hold_vld"}, 32'(rpt_valid), 32'd1);
            chk({tag, "_hold_id"}, 32'(rpt_id), 32'(e.id));
            chk({tag, "_hold_data"}, 32'(rpt_data), 32'(e.data));
        end
        collect_report(tag);
    endtask

    initial begin
        model_reset;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pos_map", 32'(pos_map), 32'd0);
        chk("rst_pos_change", 32'(pos_change), 32'd0);
        chk("rst_rpt_valid", 32'(rpt_valid), 32'd0);
        chk("rst_rpt_id", 32'(rpt_id), 32'd0);
        chk("rst_rpt_data", 32'(rpt_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        tick;
        tick;
        rst_n = 1'b1;

        // Stray rpt_ready with nothing pending
        rpt_ready = 1'b1;
        tick;
        tick;
        rpt_ready = 1'b0;
        chk("idle_rdy_vld", 32'(rpt_valid), 32'd0);
        chk("idle_rdy_req_ready", 32'(req_ready), 32'd1);

        // Three high samples flip ch1
        smp_run("t1a", 2'd1, 12'd600, 2, 4'b0000);
        smp_run("t1b", 2'd1, 12'd600, 1, 4'b0010);
        tick;
        chk("t1_chg_one_cycle", 32'(pos_change), 32'd0);
`ifndef POS_AUTO_REPORT_EN
        repeat (5) tick;
        chk("t1_no_auto_report", 32'(rpt_valid), 32'd0);
`endif

        // Neutral sample restarts the debounce count
        do_reset;
        smp_run("t2a", 2'd1, 12'd600, 1, 4'b0000);
        smp_run("t2b", 2'd1, 12'd515, 1, 4'b0000);
        smp_run("t2c", 2'd1, 12'd600, 2, 4'b0000);
        smp_run("t2d", 2'd1, 12'd600, 1, 4'b0010);
        smp_run("t2e", 2'd1, 12'd490, 2, 4'b0010);
        smp_run("t2f", 2'd1, 12'd490, 1, 4'b0000);

        // Same-cycle threshold write: sample judged against old threshold
        thr_we = 1'b1; thr_ch = 2'd0; thr_data = 12'd100;
        smp_valid = 1'b1; smp_ch = 2'd0; smp_data = 12'd200;
        tick;
        thr_we = 1'b0; smp_valid = 1'b0;
        last_smp[0] = 12'd200;
        chk("t3_same_cycle_map", 32'(pos_map), 32'd0);
        smp_run("t3a", 2'd0, 12'd200, 2, 4'b0000);
        smp_run("t3b", 2'd0, 12'd200, 1, 4'b0001);

        // hi saturates at full scale: 4095 never qualifies high
        write_thr(2'd3, 12'd4090);
        smp_run("t4_hi_sat", 2'd3, 12'd4095, 3, 4'b0001);

        // lo clamps at zero: 0 never qualifies low
        write_thr(2'd2, 12'd10);
        smp_run("t4_set2", 2'd2, 12'hABC, 3, 4'b0101);
        smp_run("t4_lo_clamp", 2'd2, 12'd0, 3, 4'b0101);
        smp_run("t4_last", 2'd2, 12'hABC, 1, 4'b0101);

        run_req("r02", 8'h02, 5);
        run_req("r07", 8'h07, 0);

        smp_run("t5a", 2'd0, 12'd50, 3, 4'b0100);
        write_thr(2'd2, 12'd2000);
        smp_run("t5b", 2'd2, 12'd100, 3, 4'b0000);
        smp_run("t5c", 2'd1, 12'd600, 3, 4'b0010);
        write_thr(2'd3, 12'd511);
        smp_run("t5d", 2'd3, 12'd4095, 3, 4'b1010);
        run_req("rF0", 8'hF0, 2);
        run_req("r01", 8'h01, 0);

        // Reset during SEND discards the report
        req_id = 8'h00;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        chk("rs_send_vld", 32'(rpt_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_drop", 32'(rpt_valid), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        model_reset;
        chk("rs_req_ready", 32'(req_ready), 32'd1);
        chk("rs_rpt_valid", 32'(rpt_valid), 32'd0);
        chk("rs_rpt_data", 32'(rpt_data), 32'd0);
        chk("rs_pos_map", 32'(pos_map), 32'd0);
        run_req("r00_post_rst", 8'h00, 0);

`ifdef POS_AUTO_REPORT_EN
        // Two flips while a report is stalled merge into one map report
        sb_q.push_back(model(8'h07));
        req_id = 8'h07;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) send_smp(2'd0, 12'd600);
        for (int i = 0; i < 3; i++) send_smp(2'd1, 12'd600);
        exp_map = 4'b0011;
        chk("auto_map", 32'(pos_map), 32'd3);
        chk("auto_stalled_vld", 32'(rpt_valid), 32'd1);
        sb_q.push_back('{id: MAP_ID, data: 16'h0003});
        collect_report("auto_err");
        collect_report("auto_map");
        begin
            int extra = 0;
            for (int i = 0; i < 10; i++) begin
                tick;
                if (rpt_valid) extra++;
            end
            chk("auto_single_report", 32'(extra), 32'd0);
        end
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
